// File: rtl/overlay_sequencer.sv
// Frame-synchronous overlay visibility sequencer: game state -> per-layer enables, with blanking
// between states and frame-counted blinking; all outputs registered. Blink logic needs OVERLAY_BLINK_EN.
module overlay_sequencer #(
    parameter int                                NUM_STATES   = 4,
    parameter int                                NUM_LAYERS   = 6,
    parameter logic [NUM_STATES*NUM_LAYERS-1:0]  VIS_MAP      = 24'h002B11,
    parameter logic [NUM_LAYERS-1:0]             BLINK_MAP    = 6'b010000,
    parameter int                                BLANK_FRAMES = 2,
    parameter int                                BLINK_FRAMES = 30,
    localparam int                               STATE_W      = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  startOfFrame,
    input  logic [STATE_W-1:0]    gameState,
    output logic [NUM_LAYERS-1:0] layerVisible,
    output logic                  transitionActive,
    output logic                  blinkPhase,
    output logic [STATE_W-1:0]    curState
);

    localparam int FRAME_W = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
    localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

    typedef enum logic {
        ST_STEADY = 1'b0,
        ST_BLANK  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [STATE_W-1:0]      cur_q, cur_d;
    logic [STATE_W-1:0]      target_q, target_d;
    logic [FRAME_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic [NUM_LAYERS-1:0]   vis_q, vis_d;
    logic                    trans_q, trans_d;
    logic                    restart_blink;
    logic [NUM_LAYERS-1:0]   row_cur;
    logic [NUM_LAYERS-1:0]   blink_mask;

    // States at or above NUM_STATES match no row and therefore show nothing.
    always_comb begin
        row_cur = '0;
        for (int s = 0; s < NUM_STATES; s++) begin
            if (cur_q == STATE_W'(s)) begin
                row_cur = VIS_MAP[s*NUM_LAYERS +: NUM_LAYERS];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        target_d      = target_q;
        frame_cnt_d   = frame_cnt_q;
        restart_blink = 1'b0;
        vis_d         = '0;
        trans_d       = 1'b0;

        if (state_q == ST_BLANK) begin
            trans_d = 1'b1;
        end else begin
            vis_d = row_cur & ~blink_mask;
        end

        case (state_q)
            ST_STEADY: begin
                if (gameState != cur_q) begin
                    target_d    = gameState;
                    frame_cnt_d = '0;
                    if (BLANK_FRAMES > 0) begin
                        state_d = ST_BLANK;
                    end else begin
                        cur_d         = gameState;
                        restart_blink = 1'b1;
                    end
                end
            end
            ST_BLANK: begin
                // A new request restarts the blank period; a coinciding frame pulse is dropped.
                if (gameState != target_q) begin
                    target_d    = gameState;
                    frame_cnt_d = '0;
                end else if (startOfFrame) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    if (frame_cnt_q == FRAME_W'(BLANK_FRAMES - 1)) begin
                        state_d       = ST_STEADY;
                        cur_d         = target_q;
                        restart_blink = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_STEADY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_STEADY;
            cur_q       <= '0;
            target_q    <= '0;
            frame_cnt_q <= '0;
            vis_q       <= '0;
            trans_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            target_q    <= target_d;
            frame_cnt_q <= frame_cnt_d;
            vis_q       <= vis_d;
            trans_q     <= trans_d;
        end
    end

`ifdef OVERLAY_BLINK_EN
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;

    // Counter is frozen while blanking and restarts in the shown phase on every state load.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (restart_blink) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (state_q == ST_STEADY && startOfFrame) begin
            if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign blink_mask = BLINK_MAP & {NUM_LAYERS{~blink_phase_q}};
    assign blinkPhase = blink_phase_q;
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = ^{BLINK_MAP, BLINK_FRAMES, restart_blink};
    assign blink_mask       = '0;
    assign blinkPhase       = 1'b1;
`endif

    assign layerVisible     = vis_q;
    assign transitionActive = trans_q;
    assign curState         = cur_q;

endmodule

// File: tb/tb_overlay_sequencer.sv
// Self-checking bench for overlay_sequencer: frame-level model plus literal checkpoints.
module tb_overlay_sequencer;

    localparam int              NUM_STATES   = 4;
    localparam int              NUM_LAYERS   = 6;
    localparam logic [23:0]     VIS_MAP      = 24'h002B11;
    localparam logic [5:0]      BLINK_MAP    = 6'b010000;
    localparam int              BLANK_FRAMES = 2;
    localparam int              BLINK_FRAMES = 30;
`ifdef OVERLAY_BLINK_EN
    localparam bit              BLINK_EN     = 1'b1;
`else
    localparam bit              BLINK_EN     = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       startOfFrame;
    logic [1:0] gameState;
    logic [5:0] layerVisible;
    logic       transitionActive;
    logic       blinkPhase;
    logic [1:0] curState;
    logic [5:0] layerVisible0;
    logic       transitionActive0;
    logic       blinkPhase0;
    logic [1:0] curState0;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    overlay_sequencer #(
        .NUM_STATES(NUM_STATES), .NUM_LAYERS(NUM_LAYERS), .VIS_MAP(VIS_MAP),
        .BLINK_MAP(BLINK_MAP), .BLANK_FRAMES(BLANK_FRAMES), .BLINK_FRAMES(BLINK_FRAMES)
    ) u_dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .gameState(gameState),
        .layerVisible(layerVisible), .transitionActive(transitionActive),
        .blinkPhase(blinkPhase), .curState(curState)
    );

    // Second instance without blanking, checked only at a few hand-computed points.
    overlay_sequencer #(
        .NUM_STATES(NUM_STATES), .NUM_LAYERS(NUM_LAYERS), .VIS_MAP(VIS_MAP),
        .BLINK_MAP(BLINK_MAP), .BLANK_FRAMES(0), .BLINK_FRAMES(BLINK_FRAMES)
    ) u_dut0 (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .gameState(gameState),
        .layerVisible(layerVisible0), .transitionActive(transitionActive0),
        .blinkPhase(blinkPhase0), .curState(curState0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] row_of(input int s);
        logic [23:0] m;
        m = VIS_MAP;
        if (s >= NUM_STATES) return 6'b0;
        return 6'(m >> (s * NUM_LAYERS));
    endfunction

    // Phase after n counted frames in the current state: shown for the first BLINK_FRAMES, hidden the next, ...
    function automatic bit phase_of(input int n);
        if (!BLINK_EN) return 1'b1;
        return ((n / BLINK_FRAMES) % 2) == 0;
    endfunction

    // Model: displayed state, pending target, frames still to blank, frames counted since the last load.
    bit         m_blank  = 1'b0;
    logic [1:0] m_cur    = 2'd0;
    logic [1:0] m_tgt    = 2'd0;
    int         m_left   = 0;
    int         m_frames = 0;
    logic [5:0] m_vis    = 6'd0;
    bit         m_trans  = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_blank = 1'b0; m_cur = 2'd0; m_tgt = 2'd0; m_left = 0;
            m_frames = 0; m_vis = 6'd0; m_trans = 1'b0;
        end else begin
            m_vis   = m_blank ? 6'd0 : (row_of(int'(m_cur)) & ~(phase_of(m_frames) ? 6'd0 : BLINK_MAP));
            m_trans = m_blank;
            if (!m_blank) begin
                if (gameState != m_cur) begin
                    m_tgt = gameState;
                    if (BLANK_FRAMES > 0) begin
                        m_blank = 1'b1;
                        m_left  = BLANK_FRAMES;
                        if (startOfFrame) m_frames++;
                    end else begin
                        m_cur    = gameState;
                        m_frames = 0;
                    end
                end else if (startOfFrame) begin
                    m_frames++;
                end
            end else begin
                if (gameState != m_tgt) begin
                    m_tgt  = gameState;
                    m_left = BLANK_FRAMES;
                end else if (startOfFrame) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_blank  = 1'b0;
                        m_cur    = m_tgt;
                        m_frames = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_layerVisible", 32'(layerVisible), 32'(m_vis));
            chk("model_transitionActive", 32'(transitionActive), 32'(m_trans));
            chk("model_curState", 32'(curState), 32'(m_cur));
            chk("model_blinkPhase", 32'(blinkPhase), 32'(phase_of(m_frames)));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        cyc(1);
        startOfFrame = 1'b0;
        cyc(2);
    endtask

    initial begin
        reset = 1'b1; startOfFrame = 1'b0; gameState = 2'd0;
        cyc(2);
        check_en = 1'b1;
        chk("reset_layerVisible", 32'(layerVisible), 32'h0);
        chk("reset_transitionActive", 32'(transitionActive), 32'h0);
        chk("reset_curState", 32'(curState), 32'h0);
        chk("reset_blinkPhase", 32'(blinkPhase), 32'h1);

        reset = 1'b0;
        cyc(1);
        chk("first_row0", 32'(layerVisible), 32'h11);
        chk("first_trans", 32'(transitionActive), 32'h0);
        frame(); frame();

        // 0 -> 1 with two blank frames
        gameState = 2'd1;
        cyc(1);
        chk("chg_edge_vis_old", 32'(layerVisible), 32'h11);
        chk("chg_edge_trans_low", 32'(transitionActive), 32'h0);
        chk("noblank_cur_new", 32'(curState0), 32'h1);
        chk("noblank_vis_old", 32'(layerVisible0), 32'h11);
        cyc(1);
        chk("blank_vis_zero", 32'(layerVisible), 32'h0);
        chk("blank_trans_high", 32'(transitionActive), 32'h1);
        chk("noblank_vis_new", 32'(layerVisible0), 32'h2C);
        chk("noblank_trans_low", 32'(transitionActive0), 32'h0);
        frame();
        chk("blank_after_1_frame", 32'(transitionActive), 32'h1);
        frame();
        chk("s1_vis", 32'(layerVisible), 32'h2C);
        chk("s1_cur", 32'(curState), 32'h1);
        chk("s1_trans", 32'(transitionActive), 32'h0);

        // 1 -> 2, one frame, then 2 -> 3 restarts the blank
        gameState = 2'd2;
        cyc(1);
        frame();
        gameState = 2'd3;
        cyc(1);
        frame();
        chk("restart_still_blank", 32'(transitionActive), 32'h1);
        chk("restart_cur_old", 32'(curState), 32'h1);
        frame();
        chk("s3_cur", 32'(curState), 32'h3);
        chk("s3_vis", 32'(layerVisible), 32'h0);
        chk("s3_trans", 32'(transitionActive), 32'h0);

        // change coinciding with a frame pulse: that pulse does not count
        gameState = 2'd0; startOfFrame = 1'b1;
        cyc(1);
        startOfFrame = 1'b0;
        cyc(1);
        frame();
        chk("coincide_still_blank", 32'(transitionActive), 32'h1);
        frame();
        chk("coincide_cur", 32'(curState), 32'h0);
        chk("coincide_vis", 32'(layerVisible), 32'h11);

        // request returns to the displayed state mid-blank
        gameState = 2'd2;
        cyc(1);
        frame();
        gameState = 2'd0;
        cyc(1);
        frame(); frame();
        chk("return_cur", 32'(curState), 32'h0);
        chk("return_trans", 32'(transitionActive), 32'h0);

        // reset during blank
        gameState = 2'd1;
        cyc(2);
        chk("pre_reset_blank", 32'(transitionActive), 32'h1);
        reset = 1'b1; gameState = 2'd0;
        cyc(1);
        chk("rst_mid_cur", 32'(curState), 32'h0);
        chk("rst_mid_trans", 32'(transitionActive), 32'h0);
        chk("rst_mid_vis", 32'(layerVisible), 32'h0);
        reset = 1'b0;
        cyc(1);
        chk("rst_mid_row0", 32'(layerVisible), 32'h11);

        // 100 frames in state 0
        repeat (30) frame();
`ifdef OVERLAY_BLINK_EN
        chk("blink_off_at_30", 32'(layerVisible[4]), 32'h0);
        chk("blink_title_on", 32'(layerVisible[0]), 32'h1);
`endif
        repeat (70) frame();
`ifndef OVERLAY_BLINK_EN
        chk("noblink_bit4_on", 32'(layerVisible[4]), 32'h1);
        chk("noblink_phase", 32'(blinkPhase), 32'h1);
`endif
        cyc(2);
        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
